// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand/result bundle for the sequential shift/add multiplier.
// The master side issues start/abort with operands; the slave side returns product, busy and done.
interface shift_add_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic                   start;
  logic                   abort;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic [2*WIDTH-1:0]     product;
  logic                   busy;
  logic                   done;

  modport master (
    output start, abort, a, b,
    input  product, busy, done
  );

  modport slave (
    input  start, abort, a, b,
    output product, busy, done
  );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shift/add iteration per clock,
// fixed WIDTH-iteration latency, start/done handshake with synchronous abort.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  shift_add_multiplier_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // abort is not sampled here, so start always wins in IDLE
          if (bus.start) begin
            state_q  <= StCalc;
            mcand_q  <= {{WIDTH{1'b0}}, bus.a};
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
          end
        end
        StCalc: begin
          if (bus.abort) begin
            state_q <= StIdle;
            acc_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            if (mplier_q[0]) begin
              acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            // always run all WIDTH iterations, even once the multiplier has drained to zero
            if (cnt_q == LastCnt) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.product = acc_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: directed scenarios plus random operands
// compared against a plain a*b reference with the expected fixed latency.
module tb_shift_add_multiplier;

  localparam int unsigned W = 8;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction; optionally holds abort with start to show start wins in IDLE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic with_abort, input string tag);
    logic [2*W-1:0] expv;
    bit             got;
    int             n;
    expv = (2*W)'(av) * (2*W)'(bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    bus.abort = with_abort;
    got = 0;
    n   = 0;
    for (int t = 1; t <= 40 && !got; t++) begin
      tick();
      if (t == 1) begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
      end
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      if (bus.done === 1'b1) begin
        got = 1;
        n   = t;
      end else begin
        checks++;
        if (bus.busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_in_calc got=%b exp=1 t=%0d", tag, bus.busy, t);
        end
      end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s done_timeout got=no_done exp=done_within_40", tag);
    end else begin
      checks++;
      if (n != W + 1) begin
        failures++;
        $display("FAIL %s latency got=%0d exp=%0d", tag, n, W + 1);
      end
      checks++;
      if (bus.product !== expv) begin
        failures++;
        $display("FAIL %s product got=%0d exp=%0d (a=%0d b=%0d)", tag, bus.product, expv, av, bv);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy_in_done got=%b exp=1", tag, bus.busy);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done got=done%b/busy%b exp=0/0", tag, bus.done, bus.busy);
    end
    checks++;
    if (bus.product !== expv) begin
      failures++;
      $display("FAIL %s product_hold got=%0d exp=%0d", tag, bus.product, expv);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    tick();
    tick();
    checks++;
    if (bus.product !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got=p%0d/b%b/d%b exp=0/0/0", bus.product, bus.busy, bus.done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    run_op(8'd13, 8'd11, 1'b0, "basic_13x11");
  endtask

  task automatic test_corners;
    run_op(8'hFF, 8'hFF, 1'b0, "ff_x_ff");
    run_op(8'h00, 8'hFF, 1'b0, "zero_x_ff");
    run_op(8'hFF, 8'h00, 1'b0, "ff_x_zero");
    run_op(8'h80, 8'h01, 1'b0, "msb_x_one");
  endtask

  task automatic test_back_to_back;
    int ndone;
    bus.a     = 8'd3;
    bus.b     = 8'd5;
    bus.start = 1'b1;
    ndone     = 0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      checks++;
      if (bus.done !== ((t % 10) == 9)) begin
        failures++;
        $display("FAIL b2b_done_timing got=%b exp=%b t=%0d", bus.done, (t % 10) == 9, t);
      end
      if (bus.done === 1'b1) begin
        ndone++;
        checks++;
        if (bus.product !== 16'd15) begin
          failures++;
          $display("FAIL b2b_product got=%0d exp=15 t=%0d", bus.product, t);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (ndone != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", ndone);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_abort;
    bus.a     = 8'd200;
    bus.b     = 8'd255;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.product !== '0) begin
      failures++;
      $display("FAIL abort_state got=p%0d/b%b/d%b exp=0/0/0", bus.product, bus.busy, bus.done);
    end
    for (int t = 0; t < 12; t++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done got=%b exp=0 t=%0d", bus.done, t);
      end
    end
    run_op(8'd7, 8'd6, 1'b0, "after_abort_7x6");
    run_op(8'd5, 8'd9, 1'b1, "start_beats_abort_idle");
  endtask

  task automatic test_reset_mid;
    bus.a     = 8'd99;
    bus.b     = 8'd77;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.product !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=p%0d/b%b/d%b exp=0/0/0", bus.product, bus.busy, bus.done);
    end
    tick();
    reset = 1'b0;
    tick();
    run_op(8'd2, 8'd9, 1'b0, "after_reset_2x9");
  endtask

  task automatic test_random;
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0, "random");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
